// File: rtl/sata_rx_prim_decoder.sv
// SATA receive dword classifier: drops ALIGNp, expands CONTp runs into repeats of the last
// primitive, forwards payload dwords and counts malformed dwords.
module sata_rx_prim_decoder #(
  parameter int DATA_BYTE_WIDTH = 4,
  parameter int ERR_CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 phy_ready,
  input  logic [31:0]          rx_data,
  input  logic [3:0]           rx_charisk,
  input  logic [3:0]           rx_err,
  input  logic                 err_cnt_clr,
  output logic [31:0]          dout,
  output logic                 dout_val,
  output logic                 prim_val,
  output logic [4:0]           prim_id,
  output logic                 cont_active,
  output logic                 bad_dword,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  generate
    if (DATA_BYTE_WIDTH != 4) begin : g_bad_width
      $error("sata_rx_prim_decoder: only DATA_BYTE_WIDTH=4 is supported");
    end
  endgenerate

  typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_CONT} state_t;

  localparam logic [4:0] P_NONE  = 5'd0;
  localparam logic [4:0] P_ALIGN = 5'd1;
  localparam logic [4:0] P_CONT  = 5'd2;

  // Handshake: none. One dword accepted every clk; every output is valid exactly one clk
  // after its input dword, and valid flags are single-cycle qualifiers with no backpressure.

  function automatic logic [4:0] lookup(input logic [31:0] d);
    logic [4:0] id;
    id = P_NONE;
    case (d)
      32'h7B4A4ABC: id = 5'd1;
      32'h9999AA7C: id = 5'd2;
      32'hB5B5957C: id = 5'd3;
      32'h4A4A957C: id = 5'd4;
      32'h5555B57C: id = 5'd5;
      32'h3535B57C: id = 5'd6;
      32'h5656B57C: id = 5'd7;
      32'h3737B57C: id = 5'd8;
      32'hD5D5B57C: id = 5'd9;
      32'h5757B57C: id = 5'd10;
      32'h5858B57C: id = 5'd11;
      32'hD5D5AA7C: id = 5'd12;
      32'h9595AA7C: id = 5'd13;
      32'h3636B57C: id = 5'd14;
      32'h1717B57C: id = 5'd15;
      32'h7575957C: id = 5'd16;
      32'h9595957C: id = 5'd17;
      32'hF5F5957C: id = 5'd18;
      default:      id = P_NONE;
    endcase
    return id;
  endfunction

  // Reset asserts immediately but releases two clk edges later, synchronised to clk.
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  logic       is_data;
  logic       is_prim;
  logic       is_bad;
  logic [4:0] prim;

  always_comb begin
    is_data = (rx_charisk == 4'b0000);
    prim    = (rx_charisk == 4'b0001) ? lookup(rx_data) : P_NONE;
    is_prim = (prim != P_NONE);
    is_bad  = !is_data && !is_prim;
  end

  state_t     state, state_nx;
  logic [4:0] last_prim, last_nx;
  logic [31:0] dout_nx;
  logic       dout_val_nx, prim_val_nx, cont_nx, bad_nx;
  logic [4:0] prim_id_nx;

  always_comb begin
    state_nx    = state;
    last_nx     = last_prim;
    dout_nx     = dout;
    dout_val_nx = 1'b0;
    prim_val_nx = 1'b0;
    prim_id_nx  = P_NONE;
    cont_nx     = 1'b0;
    bad_nx      = 1'b0;
    if (!phy_ready) begin
      state_nx = ST_IDLE;
      last_nx  = P_NONE;
    end else begin
      bad_nx = |rx_err;
      case (state)
        ST_IDLE, ST_PASS: begin
          state_nx = ST_PASS;
          if (is_data) begin
            dout_val_nx = 1'b1;
            dout_nx     = rx_data;
            last_nx     = P_NONE;
          end else if (is_bad) begin
            bad_nx = 1'b1;
          end else if (prim == P_CONT) begin
            // CONT is only meaningful after a primitive; after data or flush it is malformed.
            if (last_prim != P_NONE) begin
              prim_val_nx = 1'b1;
              prim_id_nx  = last_prim;
              cont_nx     = 1'b1;
              state_nx    = ST_CONT;
            end else begin
              bad_nx = 1'b1;
            end
          end else if (prim != P_ALIGN) begin
            prim_val_nx = 1'b1;
            prim_id_nx  = prim;
            last_nx     = prim;
          end
        end
        ST_CONT: begin
          if (is_bad) begin
            bad_nx   = 1'b1;
            state_nx = ST_PASS;
          end else if (is_prim && prim != P_ALIGN && prim != P_CONT) begin
            prim_val_nx = 1'b1;
            prim_id_nx  = prim;
            last_nx     = prim;
            state_nx    = ST_PASS;
          end else begin
            prim_val_nx = 1'b1;
            prim_id_nx  = last_prim;
            cont_nx     = 1'b1;
          end
        end
        default: begin
          state_nx = ST_IDLE;
          last_nx  = P_NONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state       <= ST_IDLE;
      last_prim   <= P_NONE;
      dout        <= '0;
      dout_val    <= 1'b0;
      prim_val    <= 1'b0;
      prim_id     <= P_NONE;
      cont_active <= 1'b0;
      bad_dword   <= 1'b0;
    end else begin
      state       <= state_nx;
      last_prim   <= last_nx;
      dout        <= dout_nx;
      dout_val    <= dout_val_nx;
      prim_val    <= prim_val_nx;
      prim_id     <= prim_id_nx;
      cont_active <= cont_nx;
      bad_dword   <= bad_nx;
    end
  end

  // Counter tracks the same-cycle bad_dword pulse; clear wins over increment.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n)               err_cnt <= '0;
    else if (err_cnt_clr)         err_cnt <= '0;
    else if (bad_nx && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
  end

endmodule
